// File: rtl/alu_op_sequencer.sv
// Sequences 16/32-bit ops onto a registered 16-bit ALU over a valid/ready command/response pair.
// Define ALU_SEQ_ADD32_EN to enable the two-step ADD32 (ISSUE_HI/WAIT_HI) path.
module alu_op_sequencer #(
    parameter logic [4:0] NOP_FUNSEL = 5'b01000
) (
    input  logic        Clock_i,
    input  logic        Reset_i,
    input  logic        CmdValid_i,
    output logic        CmdReady_o,
    input  logic [2:0]  CmdOp_i,
    input  logic [31:0] CmdA_i,
    input  logic [31:0] CmdB_i,
    output logic [15:0] ALU_A_o,
    output logic [15:0] ALU_B_o,
    output logic [4:0]  ALU_FunSel_o,
    output logic        ALU_WF_o,
    input  logic [15:0] ALU_Out_i,
    input  logic [3:0]  ALU_Flags_i,
    output logic        RspValid_o,
    input  logic        RspReady_i,
    output logic [31:0] RspData_o,
    output logic [3:0]  RspFlags_o,
    output logic        RspErr_o
);

`ifdef ALU_SEQ_ADD32_EN
    typedef enum logic [2:0] {
        IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, RESP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, ISSUE_LO, WAIT_LO, RESP
    } state_t;
`endif

    localparam logic [2:0] OP_PASS16 = 3'd0;
    localparam logic [2:0] OP_NOT16  = 3'd1;
    localparam logic [2:0] OP_ADD16  = 3'd2;
    localparam logic [2:0] OP_SUB16  = 3'd3;
    localparam logic [2:0] OP_ADD32  = 3'd4;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  flags_q, flags_d;
    logic        err_q, err_d;

    logic        legal;
    logic [4:0]  lo_fun;
    logic [4:0]  fun;
    logic        wf;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        rsp_valid;

`ifdef ALU_SEQ_ADD32_EN
    assign legal = (CmdOp_i <= OP_ADD32);
`else
    assign legal = (CmdOp_i <= OP_SUB16);
    logic unused_hi;
    assign unused_hi = ^{a_q[31:16], b_q[31:16]};
`endif

    // ADD32-low is a plain ADD so a stale ALU carry never leaks in
    always_comb begin
        lo_fun = NOP_FUNSEL;
        unique case (op_q)
            OP_PASS16: lo_fun = 5'b10000;
            OP_NOT16:  lo_fun = 5'b10010;
            OP_ADD16:  lo_fun = 5'b10100;
            OP_SUB16:  lo_fun = 5'b10110;
            OP_ADD32:  lo_fun = 5'b10100;
            default:   lo_fun = NOP_FUNSEL;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        data_d    = data_q;
        flags_d   = flags_q;
        err_d     = err_q;
        fun       = NOP_FUNSEL;
        wf        = 1'b0;
        alu_a     = 16'd0;
        alu_b     = 16'd0;
        rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (CmdValid_i) begin
                    op_d    = CmdOp_i;
                    a_d     = CmdA_i;
                    b_d     = CmdB_i;
                    data_d  = 32'd0;
                    flags_d = 4'd0;
                    err_d   = !legal;
                    state_d = legal ? ISSUE_LO : RESP;
                end
            end
            ISSUE_LO: begin
                wf      = 1'b1;
                fun     = lo_fun;
                alu_a   = a_q[15:0];
                alu_b   = b_q[15:0];
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                data_d[15:0] = ALU_Out_i;
                flags_d      = ALU_Flags_i;
`ifdef ALU_SEQ_ADD32_EN
                state_d = (op_q == OP_ADD32) ? ISSUE_HI : RESP;
`else
                state_d = RESP;
`endif
            end
`ifdef ALU_SEQ_ADD32_EN
            ISSUE_HI: begin
                wf      = 1'b1;
                fun     = 5'b10101;
                alu_a   = a_q[31:16];
                alu_b   = b_q[31:16];
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                data_d[31:16] = ALU_Out_i;
                // Z must reflect the full 32-bit sum, not just the high half
                flags_d = {({ALU_Out_i, data_q[15:0]} == 32'd0),
                           ALU_Flags_i[2:0]};
                state_d = RESP;
            end
`endif
            RESP: begin
                rsp_valid = 1'b1;
                if (RspReady_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q <= IDLE;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            data_q  <= 32'd0;
            flags_q <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    // Reset forces the ALU-facing and handshake outputs quiet within the reset cycle
    assign CmdReady_o   = (state_q == IDLE) && !Reset_i;
    assign RspValid_o   = rsp_valid && !Reset_i;
    assign ALU_FunSel_o = Reset_i ? NOP_FUNSEL : fun;
    assign ALU_WF_o     = wf && !Reset_i;
    assign ALU_A_o      = Reset_i ? 16'd0 : alu_a;
    assign ALU_B_o      = Reset_i ? 16'd0 : alu_b;
    assign RspData_o    = data_q;
    assign RspFlags_o   = flags_q;
    assign RspErr_o     = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a registered 16-bit ALU model.
// Exercises the ADD32 path when ALU_SEQ_ADD32_EN is defined, else checks op 4 as illegal.
module tb_alu_op_sequencer;

    localparam logic [4:0] NOP = 5'b01000;

    logic        Clock_i = 1'b0;
    logic        Reset_i;
    logic        CmdValid_i;
    logic        CmdReady_o;
    logic [2:0]  CmdOp_i;
    logic [31:0] CmdA_i;
    logic [31:0] CmdB_i;
    logic [15:0] ALU_A_o;
    logic [15:0] ALU_B_o;
    logic [4:0]  ALU_FunSel_o;
    logic        ALU_WF_o;
    logic [15:0] ALU_Out_i = 16'd0;
    logic [3:0]  ALU_Flags_i = 4'd0;
    logic        RspValid_o;
    logic        RspReady_i;
    logic [31:0] RspData_o;
    logic [3:0]  RspFlags_o;
    logic        RspErr_o;

    int total = 0;
    int bad = 0;
    int wf_cnt = 0;
    int w0;
    logic cy = 1'b0;

    alu_op_sequencer #(.NOP_FUNSEL(NOP)) dut (
        .Clock_i(Clock_i), .Reset_i(Reset_i),
        .CmdValid_i(CmdValid_i), .CmdReady_o(CmdReady_o),
        .CmdOp_i(CmdOp_i), .CmdA_i(CmdA_i), .CmdB_i(CmdB_i),
        .ALU_A_o(ALU_A_o), .ALU_B_o(ALU_B_o),
        .ALU_FunSel_o(ALU_FunSel_o), .ALU_WF_o(ALU_WF_o),
        .ALU_Out_i(ALU_Out_i), .ALU_Flags_i(ALU_Flags_i),
        .RspValid_o(RspValid_o), .RspReady_i(RspReady_i),
        .RspData_o(RspData_o), .RspFlags_o(RspFlags_o),
        .RspErr_o(RspErr_o)
    );

    always #5 Clock_i = ~Clock_i;

    // Registered ALU: result and {Z,C,N,O} appear one edge after FunSel is sampled
    always @(posedge Clock_i) begin
        logic [16:0] s;
        logic ov;
        if (ALU_WF_o) begin
            s = 17'd0;
            ov = 1'b0;
            case (ALU_FunSel_o)
                5'b10000: s = {1'b0, ALU_A_o};
                5'b10010: s = {1'b0, ~ALU_A_o};
                5'b10100: begin
                    s = {1'b0, ALU_A_o} + {1'b0, ALU_B_o};
                    ov = (ALU_A_o[15] == ALU_B_o[15]) && (s[15] != ALU_A_o[15]);
                end
                5'b10101: begin
                    s = {1'b0, ALU_A_o} + {1'b0, ALU_B_o} + {16'd0, cy};
                    ov = (ALU_A_o[15] == ALU_B_o[15]) && (s[15] != ALU_A_o[15]);
                end
                5'b10110: begin
                    s = {1'b0, ALU_A_o} + {1'b0, ~ALU_B_o} + 17'd1;
                    ov = (ALU_A_o[15] != ALU_B_o[15]) && (s[15] != ALU_A_o[15]);
                end
                default: s = 17'd0;
            endcase
            ALU_Out_i   <= s[15:0];
            cy          <= s[16];
            ALU_Flags_i <= {(s[15:0] == 16'd0), s[16], s[15], ov};
        end
    end

    always @(posedge Clock_i) begin
        if (ALU_WF_o) wf_cnt <= wf_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock_i);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        chk("cmd_ready_pre", {31'd0, CmdReady_o}, 32'd1);
        CmdValid_i = 1'b1;
        CmdOp_i = op;
        CmdA_i = a;
        CmdB_i = b;
        tick();
        CmdValid_i = 1'b0;
    endtask

    initial begin
        Reset_i = 1'b1;
        CmdValid_i = 1'b0;
        CmdOp_i = 3'd0;
        CmdA_i = 32'd0;
        CmdB_i = 32'd0;
        RspReady_i = 1'b0;
        #1;
        chk("rst_cmd_ready", {31'd0, CmdReady_o}, 32'd0);
        chk("rst_funsel", {27'd0, ALU_FunSel_o}, {27'd0, NOP});
        chk("rst_wf", {31'd0, ALU_WF_o}, 32'd0);
        tick();
        chk("rst_valid", {31'd0, RspValid_o}, 32'd0);
        chk("rst_data", RspData_o, 32'd0);
        chk("rst_flags", {28'd0, RspFlags_o}, 32'd0);
        chk("rst_err", {31'd0, RspErr_o}, 32'd0);
        chk("rst_alu_ab", {ALU_A_o, ALU_B_o}, 32'd0);
        chk("rst_cmd_ready2", {31'd0, CmdReady_o}, 32'd0);
        Reset_i = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, CmdReady_o}, 32'd1);

        // ADD16 0x7FFF + 1: signed overflow into negative
        RspReady_i = 1'b1;
        issue(3'd2, 32'h0000_7FFF, 32'h0000_0001);
        chk("add16_funsel", {27'd0, ALU_FunSel_o}, 32'h14);
        chk("add16_wf", {31'd0, ALU_WF_o}, 32'd1);
        chk("add16_ab", {ALU_A_o, ALU_B_o}, 32'h7FFF_0001);
        chk("add16_busy", {31'd0, CmdReady_o}, 32'd0);
        chk("add16_v0", {31'd0, RspValid_o}, 32'd0);
        tick();
        chk("add16_wait_nop", {27'd0, ALU_FunSel_o}, {27'd0, NOP});
        chk("add16_wait_wf", {31'd0, ALU_WF_o}, 32'd0);
        chk("add16_v1", {31'd0, RspValid_o}, 32'd0);
        tick();
        chk("add16_valid", {31'd0, RspValid_o}, 32'd1);
        chk("add16_data", RspData_o, 32'h0000_8000);
        chk("add16_flags", {28'd0, RspFlags_o}, 32'h3);
        chk("add16_err", {31'd0, RspErr_o}, 32'd0);
        tick();
        chk("add16_done_v", {31'd0, RspValid_o}, 32'd0);
        chk("add16_done_rdy", {31'd0, CmdReady_o}, 32'd1);

        // PASS16 drops the upper operand half
        issue(3'd0, 32'hABCD_1234, 32'h0000_0000);
        chk("pass_funsel", {27'd0, ALU_FunSel_o}, 32'h10);
        tick();
        tick();
        chk("pass_data", RspData_o, 32'h0000_1234);
        chk("pass_flags", {28'd0, RspFlags_o}, 32'h0);
        tick();

        // SUB16 equal operands: zero with no borrow
        issue(3'd3, 32'h0000_0005, 32'h0000_0005);
        chk("sub_funsel", {27'd0, ALU_FunSel_o}, 32'h16);
        tick();
        tick();
        chk("sub_valid", {31'd0, RspValid_o}, 32'd1);
        chk("sub_data", RspData_o, 32'h0000_0000);
        chk("sub_flags", {28'd0, RspFlags_o}, 32'hC);
        tick();

        // NOT16 with back-pressure and a competing command held on the input
        RspReady_i = 1'b0;
        issue(3'd1, 32'h0000_00FF, 32'h0000_0000);
        chk("not_funsel", {27'd0, ALU_FunSel_o}, 32'h12);
        tick();
        tick();
        CmdValid_i = 1'b1;
        CmdOp_i = 3'd0;
        CmdA_i = 32'h0000_1111;
        for (int i = 0; i < 5; i++) begin
            chk("not_hold_valid", {31'd0, RspValid_o}, 32'd1);
            chk("not_hold_data", RspData_o, 32'h0000_FF00);
            chk("not_hold_rdy", {31'd0, CmdReady_o}, 32'd0);
            tick();
        end
        chk("not_flags", {28'd0, RspFlags_o}, 32'h2);
        CmdValid_i = 1'b0;
        RspReady_i = 1'b1;
        tick();
        chk("not_idle_rdy", {31'd0, CmdReady_o}, 32'd1);
        chk("not_idle_v", {31'd0, RspValid_o}, 32'd0);

        // Illegal op 6: immediate error response, no ALU write
        RspReady_i = 1'b0;
        w0 = wf_cnt;
        issue(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("ill_valid", {31'd0, RspValid_o}, 32'd1);
        chk("ill_err", {31'd0, RspErr_o}, 32'd1);
        chk("ill_data", RspData_o, 32'd0);
        chk("ill_flags", {28'd0, RspFlags_o}, 32'd0);
        tick();
        chk("ill_hold_err", {31'd0, RspErr_o}, 32'd1);
        RspReady_i = 1'b1;
        tick();
        chk("ill_no_wf", wf_cnt - w0, 32'd0);
        chk("ill_idle", {31'd0, CmdReady_o}, 32'd1);

`ifdef ALU_SEQ_ADD32_EN
        // ADD32 carry ripples from the low into the high half
        issue(3'd4, 32'h0000_FFFF, 32'h0000_0001);
        chk("a32_lo_fun", {27'd0, ALU_FunSel_o}, 32'h14);
        chk("a32_lo_ab", {ALU_A_o, ALU_B_o}, 32'hFFFF_0001);
        tick();
        chk("a32_mid_nop", {27'd0, ALU_FunSel_o}, {27'd0, NOP});
        chk("a32_mid_wf", {31'd0, ALU_WF_o}, 32'd0);
        tick();
        chk("a32_hi_fun", {27'd0, ALU_FunSel_o}, 32'h15);
        chk("a32_hi_ab", {ALU_A_o, ALU_B_o}, 32'd0);
        tick();
        chk("a32_v3", {31'd0, RspValid_o}, 32'd0);
        tick();
        chk("a32_valid", {31'd0, RspValid_o}, 32'd1);
        chk("a32_data", RspData_o, 32'h0001_0000);
        chk("a32_flags", {28'd0, RspFlags_o}, 32'h0);
        tick();
`else
        issue(3'd4, 32'h0000_FFFF, 32'h0000_0001);
        chk("op4_valid", {31'd0, RspValid_o}, 32'd1);
        chk("op4_err", {31'd0, RspErr_o}, 32'd1);
        chk("op4_data", RspData_o, 32'd0);
        tick();
`endif

        // Reset while waiting on the low result
        RspReady_i = 1'b0;
`ifdef ALU_SEQ_ADD32_EN
        issue(3'd4, 32'h0000_FFFF, 32'h0000_0001);
`else
        issue(3'd2, 32'h0000_0001, 32'h0000_0002);
`endif
        tick();
        Reset_i = 1'b1;
        tick();
        chk("mid_rst_v", {31'd0, RspValid_o}, 32'd0);
        chk("mid_rst_fun", {27'd0, ALU_FunSel_o}, {27'd0, NOP});
        chk("mid_rst_data", RspData_o, 32'd0);
        Reset_i = 1'b0;
        #1;
        chk("mid_rst_rdy", {31'd0, CmdReady_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_rst_no_rsp", {31'd0, RspValid_o}, 32'd0);
        end

        // Recovery after the abort
        RspReady_i = 1'b1;
        issue(3'd0, 32'h0000_5555, 32'h0000_0000);
        tick();
        tick();
        chk("recov_valid", {31'd0, RspValid_o}, 32'd1);
        chk("recov_data", RspData_o, 32'h0000_5555);
        chk("recov_err", {31'd0, RspErr_o}, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: NOP_FUNSEL, 5'b01000, FunSel code the ALU decodes as no operation, so the ALU holds its outputs and internal carry.
REQ-002 Clock  in  1  single clock; all logic on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 CmdValid  in  1  command present.
REQ-005 CmdReady  out  1  sequencer can accept a command.
REQ-006 CmdOp  in  3  0=PASS16, 1=NOT16, 2=ADD16, 3=SUB16, 4=ADD32, 5-7 illegal.
REQ-007 CmdA, CmdB  in  32  operands; [15:0] used for 16-bit ops.
REQ-008 ALU_A, ALU_B  out  16  ALU operands.
REQ-009 ALU_FunSel  out  5  ALU function select.
REQ-010 ALU_WF  out  1  ALU flag write enable.
REQ-011 ALU_Out  in  16  ALU result, registered one cycle after FunSel is sampled.
REQ-012 ALU_Flags  in  4  ALU flags {Z,C,N,O}, same timing as ALU_Out.
REQ-013 RspValid  out  1  result present.
REQ-014 RspReady  in  1  consumer accepts result.
REQ-015 RspData  out  32  result; upper half zero for 16-bit ops.
REQ-016 RspFlags  out  4  {Z,C,N,O} of the operation.
REQ-017 RspErr  out  1  illegal opcode flag.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, and RESP.
REQ-019 CmdReady SHALL be 1 only in IDLE; a command is accepted on an edge where CmdValid and CmdReady are both 1, and its op and operands are latched internally.
REQ-020 A legal command SHALL cause IDLE->ISSUE_LO; an illegal command SHALL cause IDLE->RESP with RspErr=1, RspData=0, RspFlags=0, and no ALU operation issued.
REQ-021 In ISSUE states, ALU_WF SHALL be 1 and ALU_FunSel SHALL be: PASS16 10000, NOT16 10010, ADD16 10100, SUB16 10110, ADD32-low 10100, ADD32-high 10101 (add with carry); ALU_A and ALU_B carry the corresponding operand halves.
REQ-022 In all other states, ALU_FunSel SHALL be NOP_FUNSEL and ALU_WF SHALL be 0, so the ALU carry is preserved between the two ADD32 halves.
REQ-023 ISSUE_LO->WAIT_LO; WAIT_LO captures ALU_Out into RspData[15:0] and ALU_Flags, then goes to ISSUE_HI for ADD32 or to RESP otherwise.
REQ-024 ISSUE_HI->WAIT_HI; WAIT_HI captures ALU_Out into RspData[31:16] and ALU_Flags, then goes to RESP.
REQ-025 For ADD32, RspFlags[3] (Z) SHALL be 1 iff RspData==0; C, N, and O come from the high step.
REQ-026 Latency: RspValid SHALL rise 2 cycles after the accept edge for 16-bit ops, 4 cycles for ADD32, and 1 cycle for illegal ops.
REQ-027 In RESP, RspValid=1 and RspData/RspFlags/RspErr SHALL hold stable until an edge with RspReady=1, after which the FSM goes to IDLE; there is no same-cycle accept of a new command.
REQ-028 Throughput: one command in flight at most; no new command is accepted before the response handshake completes.

Reset
REQ-029 On Reset: FSM to IDLE, RspValid=0, RspData=0, RspFlags=0, RspErr=0, ALU_FunSel=NOP_FUNSEL, ALU_WF=0, ALU_A=ALU_B=0, CmdReady=0 during the reset cycle.
REQ-030 Reset asserted mid-operation or in RESP SHALL abort it; the pending response is discarded and not presented afterwards.
REQ-031 The ALU internal carry is not reset; correctness SHALL NOT depend on it, because ADD32-low uses plain ADD.

Configuration
REQ-032 Macro ALU_SEQ_ADD32_EN defined: ADD32 is supported with ISSUE_HI/WAIT_HI per REQ-021..025.
REQ-033 Macro ALU_SEQ_ADD32_EN undefined: ISSUE_HI/WAIT_HI are absent, CmdOp=4 is treated as illegal (REQ-020), and RspData[31:16] is always 0.

Verification
REQ-034 ADD16 A=0x7FFF B=0x0001, RspReady=1 -> RspValid 2 cycles after accept, RspData=0x00008000, flags N=1, O=1, Z=0, C=0.
REQ-035 SUB16 A=0x0005 B=0x0005 -> RspData=0x00000000, Z=1.
REQ-036 ADD32 A=0x0000FFFF B=0x00000001 (macro defined) -> FunSel sequence 10100, NOP, 10101; RspData=0x00010000, Z=0, RspValid 4 cycles after accept.
REQ-037 CmdOp=6 -> RspErr=1, RspData=0 one cycle after accept; ALU_WF never asserted.
REQ-038 NOT16 A=0x00FF with RspReady held 0 for 5 cycles -> RspData=0x0000FF00 stable and CmdReady=0 throughout; IDLE one cycle after RspReady=1.
REQ-039 Reset asserted in WAIT_LO of ADD32 -> next cycle RspValid=0, ALU_FunSel=NOP_FUNSEL, CmdReady=1 after Reset deasserts, no response emitted.
